// File: rtl/i2c_txn_arbiter.sv
// rtl/i2c_txn_arbiter.sv - round-robin arbiter sharing one single-byte I2C master engine among NUM_REQ requesters
// Optional watchdog (and its TIMEOUT_CYCLES parameter) enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_txn_arbiter #(
  parameter int NUM_REQ = 4
`ifdef I2C_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic                 clk_400,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [7*NUM_REQ-1:0] req_addr,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_err,
  output logic                 rsp_timeout,
  output logic                 arb_busy,
  output logic                 m_start,
  output logic [7:0]           m_addr,
  output logic [7:0]           m_wdata,
  input  logic                 m_busy,
  input  logic                 m_done,
  input  logic [7:0]           m_rdata,
  input  logic                 m_ack_error
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LAUNCH    = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_RESP      = 3'd4;

  logic [2:0]         state;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      gnt_idx;
  logic [PW-1:0]      pick_idx;
  logic [PW-1:0]      hi_idx;
  logic [PW-1:0]      lo_idx;
  logic               hi_found;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [6:0]         pick_addr;
  logic               pick_rw;
  logic [7:0]         pick_wdata;
  logic [7:0]         rdata_q;
  logic               err_q;
  logic               in_wait;
  logic               in_resp;
  logic               timeout_evt;

  // Lowest requester above ptr wins; otherwise wrap to the lowest at or below ptr.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req[j]) begin
        if (PW'(j) > ptr) begin
          hi_found = 1'b1;
          hi_idx   = PW'(j);
        end else begin
          lo_idx = PW'(j);
        end
      end
    end
    pick_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    pick_onehot = '0;
    pick_addr   = '0;
    pick_rw     = 1'b0;
    pick_wdata  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (PW'(j) == pick_idx) begin
        pick_onehot[j] = 1'b1;
        pick_addr      = req_addr[7*j +: 7];
        pick_rw        = req_rw[j];
        pick_wdata     = req_wdata[8*j +: 8];
      end
    end
  end

  assign in_wait = (state == ST_WAIT_BUSY) || (state == ST_WAIT_DONE);
  assign in_resp = (state == ST_RESP);

`ifdef I2C_ARB_TIMEOUT_EN
  // Expiry is decided one count early so RESP lands TIMEOUT_CYCLES cycles after LAUNCH.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 2);

  logic [15:0] to_cnt;
  logic        to_q;

  assign timeout_evt = in_wait && !m_done && (to_cnt == TO_LAST);

  always_ff @(posedge clk_400 or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      to_q   <= 1'b0;
    end else if (state == ST_LAUNCH) begin
      to_cnt <= '0;
      to_q   <= 1'b0;
    end else if (in_wait) begin
      to_cnt <= to_cnt + 16'd1;
      if (timeout_evt) to_q <= 1'b1;
    end
  end

  assign rsp_timeout = in_resp & to_q;
`else
  assign timeout_evt = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk_400 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ptr     <= PW'(NUM_REQ - 1);
      gnt     <= '0;
      gnt_idx <= '0;
      m_addr  <= '0;
      m_wdata <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            gnt     <= pick_onehot;
            gnt_idx <= pick_idx;
            m_addr  <= {pick_addr, pick_rw};
            m_wdata <= pick_wdata;
            state   <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: state <= ST_WAIT_BUSY;
        ST_WAIT_BUSY, ST_WAIT_DONE: begin
          // A completion in the same cycle as busy or expiry always takes precedence.
          if (m_done) begin
            rdata_q <= m_addr[0] ? m_rdata : 8'h00;
            err_q   <= m_ack_error;
            state   <= ST_RESP;
          end else if (timeout_evt) begin
            rdata_q <= 8'h00;
            err_q   <= 1'b1;
            state   <= ST_RESP;
          end else if ((state == ST_WAIT_BUSY) && m_busy) begin
            state <= ST_WAIT_DONE;
          end
        end
        ST_RESP: begin
          ptr   <= gnt_idx;
          gnt   <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign m_start   = (state == ST_LAUNCH);
  assign arb_busy  = (state != ST_IDLE);
  assign rsp_valid = in_resp ? gnt : '0;
  assign rsp_rdata = in_resp ? rdata_q : 8'h00;
  assign rsp_err   = in_resp & err_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb/tb_i2c_txn_arbiter.sv - self-checking bench for i2c_txn_arbiter
// Table vectors, randomized transfers against a round-robin reference model, reset and watchdog sequences.
module tb_i2c_txn_arbiter;
  localparam int N = 4;

  logic           clk_400 = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [7*N-1:0] req_addr;
  logic [N-1:0]   req_rw;
  logic [8*N-1:0] req_wdata;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rsp_valid;
  logic [7:0]     rsp_rdata;
  logic           rsp_err;
  logic           rsp_timeout;
  logic           arb_busy;
  logic           m_start;
  logic [7:0]     m_addr;
  logic [7:0]     m_wdata;
  logic           m_busy;
  logic           m_done;
  logic [7:0]     m_rdata;
  logic           m_ack_error;

  always #5 clk_400 = ~clk_400;

`ifdef I2C_ARB_TIMEOUT_EN
  i2c_txn_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
`else
  i2c_txn_arbiter #(.NUM_REQ(N)) dut (
`endif
    .clk_400(clk_400), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .arb_busy(arb_busy), .m_start(m_start),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_busy(m_busy), .m_done(m_done),
    .m_rdata(m_rdata), .m_ack_error(m_ack_error)
  );

  typedef struct {
    logic [3:0] rq;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wd;
    logic [7:0] rd;
    logic       nack;
    int         busy;
    int         eg;
    logic [7:0] ema;
    logic [7:0] erd;
    logic       eerr;
  } vec_t;

  int         n_vec = 0;
  int         n_bad = 0;
  int         ref_ptr;
  logic [6:0] ra[N];
  logic       rw_a[N];
  logic [7:0] wd_a[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r);
    for (int k = 1; k <= N; k++)
      if (r[(ref_ptr + k) % N]) return (ref_ptr + k) % N;
    return 0;
  endfunction

  task automatic apply_cfg();
    for (int i = 0; i < N; i++) begin
      req_addr[7*i +: 7]  = ra[i];
      req_rw[i]           = rw_a[i];
      req_wdata[8*i +: 8] = wd_a[i];
    end
  endtask

  task automatic run_txn(input string tag, input logic [N-1:0] rq, input int busy_n,
                         input logic [7:0] rd, input logic nack, input bit drop_early,
                         input int eg, input logic [7:0] ema, input logic [7:0] emw,
                         input logic [7:0] erd, input logic eerr);
    int n;
    logic [N-1:0] eg_hot;
    eg_hot = N'(1) << eg;
    @(negedge clk_400);
    req = rq;
    n = 0;
    while (m_start !== 1'b1 && n < 8) begin
      @(negedge clk_400);
      n++;
    end
    check({tag, " start_lat"}, n, 1);
    if (m_start !== 1'b1) begin
      req = '0;
      return;
    end
    check({tag, " gnt"}, gnt, eg_hot);
    check({tag, " m_addr"}, m_addr, ema);
    check({tag, " m_wdata"}, m_wdata, emw);
    if (drop_early) req = '0;
    if (busy_n > 0) m_busy = 1'b1;
    @(negedge clk_400);
    check({tag, " start_pulse"}, m_start, 0);
    if (busy_n > 1) repeat (busy_n - 1) @(negedge clk_400);
    check({tag, " gnt_hold"}, gnt, eg_hot);
    m_done = 1'b1;
    m_rdata = rd;
    m_ack_error = nack;
    @(negedge clk_400);
    m_done = 1'b0;
    m_busy = 1'b0;
    m_rdata = 8'($urandom);
    m_ack_error = 1'b0;
    check({tag, " rsp_valid"}, rsp_valid, eg_hot);
    check({tag, " rsp_rdata"}, rsp_rdata, erd);
    check({tag, " rsp_err"}, rsp_err, eerr);
    check({tag, " rsp_timeout"}, rsp_timeout, 0);
    check({tag, " maddr_hold"}, m_addr, ema);
    ref_ptr = eg;
    req = '0;
    @(negedge clk_400);
    check({tag, " rsp_pulse"}, rsp_valid, 0);
    check({tag, " gnt_clear"}, gnt, 0);
  endtask

  vec_t tbl[9];

  initial begin
    int n;
    int g;
    logic [N-1:0] rq;
    logic [7:0] rd;
    logic nk;
    logic seen;

    tbl[0] = '{4'b1111, 7'h50, 1'b0, 8'h11, 8'hFF, 1'b0, 1, 0, 8'hA0, 8'h00, 1'b0};
    tbl[1] = '{4'b1111, 7'h51, 1'b1, 8'h22, 8'h44, 1'b0, 0, 1, 8'hA3, 8'h44, 1'b0};
    tbl[2] = '{4'b1111, 7'h52, 1'b0, 8'h33, 8'h00, 1'b0, 3, 2, 8'hA4, 8'h00, 1'b0};
    tbl[3] = '{4'b1111, 7'h53, 1'b1, 8'h44, 8'h99, 1'b0, 2, 3, 8'hA7, 8'h99, 1'b0};
    tbl[4] = '{4'b1111, 7'h54, 1'b0, 8'h55, 8'h00, 1'b0, 1, 0, 8'hA8, 8'h00, 1'b0};
    tbl[5] = '{4'b0001, 7'h01, 1'b0, 8'hA5, 8'h00, 1'b0, 2, 0, 8'h02, 8'h00, 1'b0};
    tbl[6] = '{4'b0100, 7'h01, 1'b1, 8'h00, 8'h3C, 1'b0, 0, 2, 8'h03, 8'h3C, 1'b0};
    tbl[7] = '{4'b1010, 7'h7F, 1'b1, 8'h00, 8'h5A, 1'b1, 2, 3, 8'hFF, 8'h5A, 1'b1};
    tbl[8] = '{4'b1010, 7'h10, 1'b0, 8'hC3, 8'h00, 1'b0, 1, 1, 8'h20, 8'h00, 1'b0};

    rst_n = 1'b0;
    req = '0;
    req_addr = '0;
    req_rw = '0;
    req_wdata = '0;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_rdata = '0;
    m_ack_error = 1'b0;
    repeat (2) @(negedge clk_400);
    check("rst gnt", gnt, 0);
    check("rst rsp_valid", rsp_valid, 0);
    check("rst m_start", m_start, 0);
    check("rst arb_busy", arb_busy, 0);
    check("rst m_addr", m_addr, 0);
    check("rst m_wdata", m_wdata, 0);
    check("rst rsp_bits", {rsp_rdata, rsp_err, rsp_timeout}, 0);
    rst_n = 1'b1;
    ref_ptr = N - 1;

    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < N; i++) begin
        ra[i] = tbl[v].addr;
        rw_a[i] = tbl[v].rw;
        wd_a[i] = tbl[v].wd;
      end
      apply_cfg();
      run_txn($sformatf("tbl%0d", v), tbl[v].rq, tbl[v].busy, tbl[v].rd, tbl[v].nack, 1'b0,
              tbl[v].eg, tbl[v].ema, tbl[v].wd, tbl[v].erd, tbl[v].eerr);
    end

    // stray completion while idle
    @(negedge clk_400);
    m_done = 1'b1;
    m_rdata = 8'hFF;
    @(negedge clk_400);
    m_done = 1'b0;
    check("idle_done arb_busy", arb_busy, 0);
    check("idle_done rsp_valid", rsp_valid, 0);
    @(negedge clk_400);
    check("idle_done later", {arb_busy, rsp_valid}, 0);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        ra[i] = 7'($urandom_range(0, 127));
        rw_a[i] = 1'($urandom_range(0, 1));
        wd_a[i] = 8'($urandom);
      end
      apply_cfg();
      rq = N'($urandom_range(1, (1 << N) - 1));
      rd = 8'($urandom);
      nk = 1'($urandom_range(0, 1));
      g = rr_pick(rq);
      run_txn($sformatf("rnd%0d", t), rq, $urandom_range(0, 4), rd, nk, 1'($urandom_range(0, 1)),
              g, {ra[g], rw_a[g]}, wd_a[g], rw_a[g] ? rd : 8'h00, nk);
    end

    // async reset while waiting for completion
    @(negedge clk_400);
    req = 4'b0001;
    n = 0;
    while (m_start !== 1'b1 && n < 8) begin
      @(negedge clk_400);
      n++;
    end
    check("rst_mid launch", m_start, 1);
    m_busy = 1'b1;
    repeat (2) @(negedge clk_400);
    check("rst_mid busy", arb_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid gnt", gnt, 0);
    check("rst_mid arb_busy", arb_busy, 0);
    check("rst_mid rsp", {rsp_valid, m_start}, 0);
    req = '0;
    @(negedge clk_400);
    m_done = 1'b1;
    @(negedge clk_400);
    m_done = 1'b0;
    m_busy = 1'b0;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk_400);
      if (rsp_valid !== '0 || arb_busy !== 1'b0) seen = 1'b1;
    end
    check("rst_mid no_rsp", seen, 0);
    ref_ptr = N - 1;
    for (int i = 0; i < N; i++) begin
      ra[i] = 7'h2A + 7'(i);
      rw_a[i] = 1'b0;
      wd_a[i] = 8'h60 + 8'(i);
    end
    apply_cfg();
    run_txn("post_rst", 4'b0010, 1, 8'h00, 1'b0, 1'b0, 1, 8'h56, 8'h61, 8'h00, 1'b0);

`ifdef I2C_ARB_TIMEOUT_EN
    @(negedge clk_400);
    req = 4'b0100;
    n = 0;
    while (m_start !== 1'b1 && n < 8) begin
      @(negedge clk_400);
      n++;
    end
    check("to launch", m_start, 1);
    m_busy = 1'b1;
    n = 0;
    while (rsp_valid === '0 && n < 40) begin
      @(negedge clk_400);
      n++;
    end
    check("to latency", n, 16);
    check("to rsp_valid", rsp_valid, 4'b0100);
    check("to err", {rsp_err, rsp_timeout}, 2'b11);
    check("to rdata", rsp_rdata, 0);
    req = '0;
    @(negedge clk_400);
    m_done = 1'b1;
    m_busy = 1'b0;
    @(negedge clk_400);
    m_done = 1'b0;
    check("to late_done", {rsp_valid, arb_busy}, 0);
    ref_ptr = 2;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
